// File: rtl/int_rx_pkg.sv
// ============================================================================
// Module  : int_rx_pkg
// Brief   : Shared UART/ALU definitions: receive-FSM state codes, operand slot
//           indices and default operand/opcode widths.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package int_rx_pkg;

    localparam int NBIT_DEF = 8;
    localparam int NOP_DEF  = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEER   = 3'd1,
        ST_EXEC   = 3'd2,
        ST_ENVIAR = 3'd3
    } rx_state_t;

    localparam logic [1:0] SLOT_A  = 2'd0;
    localparam logic [1:0] SLOT_B  = 2'd1;
    localparam logic [1:0] SLOT_OP = 2'd2;

endpackage : int_rx_pkg

`default_nettype wire

// File: rtl/int_rx.sv
// ============================================================================
// Module  : int_rx
// Brief   : Assembles {operand A, operand B, opcode} frames from the RX FIFO
//           and hands each complete frame to the transmit side.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module int_rx
    import int_rx_pkg::*;
#(
    parameter int NBIT = NBIT_DEF,
    parameter int NOP  = NOP_DEF
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            fifo_empty,
    input  logic [NBIT-1:0] DATA_FIFO,
    input  logic            tx_idle,
    output logic            RD_FIFO,
    output logic [NBIT-1:0] DATO_A,
    output logic [NBIT-1:0] DATO_B,
    output logic [NOP-1:0]  OPCODE,
    output logic            enviar,
    output logic [2:0]      STATE
);

    rx_state_t       state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [NBIT-1:0] dato_a_q, dato_a_d;
    logic [NBIT-1:0] dato_b_q, dato_b_d;
    logic [NOP-1:0]  opcode_q, opcode_d;
    logic            rd_d;
    logic            env_d;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            cnt_q    <= SLOT_A;
            dato_a_q <= '0;
            dato_b_q <= '0;
            opcode_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dato_a_q <= dato_a_d;
            dato_b_q <= dato_b_d;
            opcode_q <= opcode_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dato_a_d = dato_a_q;
        dato_b_d = dato_b_q;
        opcode_d = opcode_q;
        rd_d     = 1'b0;
        env_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    rd_d    = 1'b1;
                    state_d = ST_LEER;
                end
            end

            // Read data arrives one cycle after the strobe, so capture here.
            ST_LEER: begin
                case (cnt_q)
                    SLOT_A:  dato_a_d = DATA_FIFO;
                    SLOT_B:  dato_b_d = DATA_FIFO;
                    default: opcode_d = DATA_FIFO[NOP-1:0];
                endcase
                if (cnt_q < SLOT_OP) begin
                    cnt_d   = cnt_q + 2'd1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                state_d = ST_ENVIAR;
            end

            ST_ENVIAR: begin
                if (tx_idle) begin
                    env_d   = 1'b1;
                    cnt_d   = SLOT_A;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Gated by RESET so both strobes drop the moment reset is applied.
    assign RD_FIFO = rd_d  & ~RESET;
    assign enviar  = env_d & ~RESET;
    assign DATO_A  = dato_a_q;
    assign DATO_B  = dato_b_q;
    assign OPCODE  = opcode_q;
    assign STATE   = state_q;

endmodule : int_rx

`default_nettype wire

// File: tb/tb_int_rx.sv
// ============================================================================
// Module  : tb_int_rx
// Brief   : Scoreboard bench for int_rx with a behavioural RX FIFO.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_int_rx;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       fifo_empty = 1'b1;
    logic [7:0] DATA_FIFO = 8'h00;
    logic       tx_idle = 1'b1;
    logic       RD_FIFO;
    logic [7:0] DATO_A;
    logic [7:0] DATO_B;
    logic [5:0] OPCODE;
    logic       enviar;
    logic [2:0] STATE;

    int_rx #(.NBIT(8), .NOP(6)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .fifo_empty (fifo_empty),
        .DATA_FIFO  (DATA_FIFO),
        .tx_idle    (tx_idle),
        .RD_FIFO    (RD_FIFO),
        .DATO_A     (DATO_A),
        .DATO_B     (DATO_B),
        .OPCODE     (OPCODE),
        .enviar     (enviar),
        .STATE      (STATE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
        int         lat;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fq[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         gap_until = 0;
    logic       rd_pend = 1'b0;
    int         rd_cnt = 0;
    int         t_start = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
        end
    endtask

    task automatic push_frame(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] opb, input logic [5:0] op, input int lat);
        exp_t e;
        fq.push_back(a);
        fq.push_back(b);
        fq.push_back(opb);
        e.a = a; e.b = b; e.op = op; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string nm);
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge CLK);
            if (exp_q.size() == 0 && fq.size() == 0 && STATE == 3'd0) break;
        end
        n_cmp++;
        if (k == 300) begin
            n_err++;
            $display("FAIL %s: drain timeout, got %0d frames outstanding, expected 0", nm, exp_q.size());
        end
    endtask

    // FIFO model: read data becomes valid in the cycle after the strobe.
    always @(posedge CLK) begin
        cyc++;
        #1;
        if (rd_pend && fq.size() > 0) DATA_FIFO = fq.pop_front();
        fifo_empty = (fq.size() == 0) || (cyc < gap_until);
    end

    // Monitor: protocol checks every cycle, scoreboard pop on each enviar.
    always @(negedge CLK) begin
        exp_t e;
        rd_pend = RD_FIFO;
        if (RESET) begin
            rd_cnt = 0;
        end else begin
            if (RD_FIFO) begin
                if (rd_cnt == 0) t_start = cyc;
                rd_cnt = (rd_cnt == 2) ? 0 : rd_cnt + 1;
            end
            chk("protocol", {31'd0, !((RD_FIFO && (fifo_empty || STATE != 3'd0)) ||
                                     (enviar && STATE != 3'd3))}, 32'd1);
            if (enviar) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL spurious_enviar: got pulse at cycle %0d, expected none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("dato_a", {24'd0, DATO_A}, {24'd0, e.a});
                    chk("dato_b", {24'd0, DATO_B}, {24'd0, e.b});
                    chk("opcode", {26'd0, OPCODE}, {26'd0, e.op});
                    if (e.lat >= 0) chk("latency", cyc - t_start, e.lat);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1);
    end

    initial begin
        int k;
        // Reset state
        #3;
        chk("rst_state", {29'd0, STATE}, 32'd0);
        chk("rst_a", {24'd0, DATO_A}, 32'd0);
        chk("rst_b", {24'd0, DATO_B}, 32'd0);
        chk("rst_op", {26'd0, OPCODE}, 32'd0);
        chk("rst_rd", {31'd0, RD_FIFO}, 32'd0);
        chk("rst_env", {31'd0, enviar}, 32'd0);
        @(negedge CLK); #1 RESET = 1'b0;
        @(negedge CLK);

        // Basic frame, unstalled: enviar in the 8th cycle of the frame
        push_frame(8'h05, 8'h03, 8'h20, 6'h20, 7);
        wait_drain("basic");

        // Opcode upper bits discarded
        push_frame(8'h10, 8'h20, 8'hE2, 6'h22, 7);
        wait_drain("opcode_trunc");

        // FIFO empty gap between bytes 1 and 2
        fq.push_back(8'h11);
        for (k = 0; k < 50; k++) begin
            @(negedge CLK);
            if (fq.size() == 0) break;
        end
        gap_until = cyc + 6;
        fq.push_back(8'h22);
        fq.push_back(8'h23);
        begin
            exp_t e;
            e.a = 8'h11; e.b = 8'h22; e.op = 6'h23; e.lat = -1;
            exp_q.push_back(e);
        end
        for (k = 0; k < 5; k++) begin
            @(negedge CLK);
            chk("gap_rd", {31'd0, RD_FIFO}, 32'd0);
        end
        wait_drain("gap");

        // tx_idle stall in ENVIAR with the next frame already waiting
        tx_idle = 1'b0;
        push_frame(8'h33, 8'h44, 8'h25, 6'h25, -1);
        push_frame(8'h55, 8'h66, 8'h26, 6'h26, 7);
        for (k = 0; k < 50; k++) begin
            @(negedge CLK);
            if (STATE == 3'd3) break;
        end
        for (k = 0; k < 10; k++) begin
            @(negedge CLK);
            chk("stall_state", {29'd0, STATE}, 32'd3);
            chk("stall_rd", {31'd0, RD_FIFO}, 32'd0);
            chk("stall_env", {31'd0, enviar}, 32'd0);
        end
        tx_idle = 1'b1;
        wait_drain("stall");

        // Reset after two bytes discards the partial frame
        fq.push_back(8'h77);
        fq.push_back(8'h66);
        for (k = 0; k < 50; k++) begin
            @(negedge CLK);
            if (fq.size() == 0 && STATE == 3'd0) break;
        end
        #2 RESET = 1'b1;
        #1;
        chk("midrst_state", {29'd0, STATE}, 32'd0);
        chk("midrst_a", {24'd0, DATO_A}, 32'd0);
        chk("midrst_b", {24'd0, DATO_B}, 32'd0);
        chk("midrst_op", {26'd0, OPCODE}, 32'd0);
        @(negedge CLK); #1 RESET = 1'b0;
        push_frame(8'h09, 8'h01, 8'h21, 6'h21, 7);
        wait_drain("post_reset");

        // Back-to-back frames
        push_frame(8'h01, 8'h02, 8'h20, 6'h20, 7);
        push_frame(8'h07, 8'h04, 8'h22, 6'h22, 7);
        wait_drain("back_to_back");

        repeat (3) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_int_rx

`default_nettype wire

// File: doc/int_rx.md
INT_RX -- requirements
Module: int_rx

Interface
REQ-001 Parameter NBIT, default 8, data/operand width in bits.
REQ-002 Parameter NOP, default 6, opcode width in bits; NOP <= NBIT.
REQ-003 CLK  input  1  system clock; all state updates on rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 fifo_empty  input  1  RX FIFO empty flag.
REQ-006 DATA_FIFO  input  NBIT  RX FIFO read data; valid the cycle after RD_FIFO is asserted.
REQ-007 tx_idle  input  1  high when the downstream transmit interface can accept a start.
REQ-008 RD_FIFO  output  1  one-cycle RX FIFO read strobe.
REQ-009 DATO_A  output  NBIT  registered ALU operand A.
REQ-010 DATO_B  output  NBIT  registered ALU operand B.
REQ-011 OPCODE  output  NOP  registered ALU opcode.
REQ-012 enviar  output  1  one-cycle start pulse to the transmit interface.
REQ-013 STATE  output  3  current FSM state code, for debug.

Function
REQ-014 A frame is three consecutive FIFO bytes in this order: operand A, operand B, opcode.
REQ-015 The FSM SHALL have states IDLE=0, LEER=1, EXEC=2, ENVIAR=3; codes 4-7 are unused and return to IDLE.
REQ-016 IDLE: when fifo_empty=0, assert RD_FIFO for exactly this cycle and go to LEER; otherwise remain in IDLE with RD_FIFO=0.
REQ-017 LEER: capture DATA_FIFO into the slot selected by a 2-bit byte counter (0->DATO_A, 1->DATO_B, 2->OPCODE); RD_FIFO=0.
REQ-018 LEER: if counter<2, increment the counter and return to IDLE; if counter=2, go to EXEC.
REQ-019 OPCODE SHALL take DATA_FIFO[NOP-1:0]; the upper bits are discarded.
REQ-020 EXEC: one settling cycle for the combinational ALU; outputs held; go to ENVIAR.
REQ-021 ENVIAR: if tx_idle=1, assert enviar for this cycle, clear the counter and go to IDLE; otherwise stay with enviar=0.
REQ-022 enviar SHALL assert at most once per frame and never outside ENVIAR.
REQ-023 RD_FIFO SHALL never assert when fifo_empty=1, nor in any state other than IDLE.
REQ-024 Throughput: at least 2 cycles per byte; minimum frame-to-enviar latency is 3 read pairs + EXEC + ENVIAR = 8 cycles.
REQ-025 DATO_A, DATO_B and OPCODE SHALL hold their values until overwritten by the next frame's capture of the same slot.
REQ-026 No bytes are read while in EXEC or ENVIAR; the FIFO provides the backpressure during a tx_idle stall.
REQ-027 All outputs SHALL be registered or decoded from state only, with no combinational path from inputs to RD_FIFO or enviar other than through the fifo_empty and tx_idle qualifiers.

Reset
REQ-028 RESET SHALL force STATE=IDLE, counter=0, DATO_A=0, DATO_B=0, OPCODE=0, RD_FIFO=0 and enviar=0 immediately.
REQ-029 Reset mid-frame SHALL discard the partial frame; the next byte read is treated as operand A.

Structure
REQ-030 State codes, slot indices, and the NBIT/NOP defaults SHALL live in the shared UART/ALU package used by the transmit interface.
REQ-031 Single flat module; no sub-module.

Verification
REQ-032 FIFO bytes 0x05, 0x03, 0x20 with tx_idle=1 -> DATO_A=0x05, DATO_B=0x03, OPCODE=0x20; one enviar pulse 8 cycles after the first RD_FIFO.
REQ-033 Opcode byte 0xE2 -> OPCODE=0x22.
REQ-034 fifo_empty=1 for 5 cycles between bytes 1 and 2 -> RD_FIFO stays 0 during the gap; the frame completes correctly.
REQ-035 tx_idle=0 for 10 cycles in ENVIAR -> STATE=3 held, no RD_FIFO, enviar once after tx_idle rises.
REQ-036 RESET after 2 bytes, then bytes 0x09, 0x01, 0x21 -> DATO_A=0x09, DATO_B=0x01, OPCODE=0x21, single enviar.
REQ-037 Two back-to-back frames (0x01, 0x02, 0x20 then 0x07, 0x04, 0x22) -> two enviar pulses with operands updated per frame.
